pwm_led_decoder: RTL and testbench

//  Receive end of the 3-channel accumulator-carry PWM LED drive: counts carry pulses per

---
 rtl/pwm_led_decoder.sv | 137 +++++++++++++
 tb/tb_pwm_led_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_led_decoder.sv
// pwm_led_decoder: receive side of the 3-channel accumulator-carry PWM LED drive.
// Counts carry pulses per channel over windows of 2**WIDTH accepted samples and
// recovers the intensity code that produced each stream.
// Optional feature: define PWM_LED_DEC_CHANGE_EN to add the 'changed' output,
// which flags level updates that differ from the previous window.
//
// Handshake: sample_en is a plain strobe with no back-pressure; one synchronized
// sample is accepted on every clk where sample_en=1 (and clear=0). level_valid is
// a one-cycle pulse; levels are stable whenever level_valid is high and are held
// until the next update.
module pwm_led_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             clear,
  input  logic [2:0]       pdm_in,
  output logic [WIDTH-1:0] level_b,
  output logic [WIDTH-1:0] level_g,
  output logic [WIDTH-1:0] level_r,
  output logic             level_valid,
  output logic             sat_err,
`ifdef PWM_LED_DEC_CHANGE_EN
  output logic             changed,
`endif
  output logic             fsm_state
);

  localparam logic FLUSH   = 1'b0;
  localparam logic MEASURE = 1'b1;
  localparam int   FW      = $clog2(SYNC_STAGES + 1);

  logic             state;
  logic [FW-1:0]    flush_cnt;
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       synced;
  logic [WIDTH-1:0] win_cnt;
  logic [WIDTH:0]   ones_cnt  [3];
  logic [WIDTH:0]   ones_next [3];
  logic [WIDTH-1:0] sat_lvl   [3];
  logic [WIDTH-1:0] level_q   [3];
  logic             any_sat;
  logic             accept;
  logic             final_sample;

  assign synced       = sync_q[SYNC_STAGES-1];
  assign accept       = (state == MEASURE) && sample_en && !clear;
  assign final_sample = accept && (win_cnt == '1);
  assign fsm_state    = state;
  assign level_b      = level_q[0];
  assign level_g      = level_q[1];
  assign level_r      = level_q[2];

  // Next ones count including the current sample, and its saturated level value.
  always_comb begin
    any_sat = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ones_next[c] = ones_cnt[c] + (WIDTH+1)'(synced[c]);
      sat_lvl[c]   = ones_next[c][WIDTH] ? '1 : ones_next[c][WIDTH-1:0];
      if (ones_next[c][WIDTH]) any_sat = 1'b1;
    end
  end

  // Input synchronizer, free-running regardless of sample_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pdm_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // FSM: discard SYNC_STAGES strobes after reset so stale synchronizer data never counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FLUSH;
      flush_cnt <= '0;
    end else if (state == FLUSH && sample_en) begin
      if (flush_cnt == FW'(SYNC_STAGES - 1)) begin
        state     <= MEASURE;
        flush_cnt <= '0;
      end else begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // Window and ones counters; restart on window wrap so no sample is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt <= '0;
      for (int c = 0; c < 3; c++) ones_cnt[c] <= '0;
    end else if (clear) begin
      win_cnt <= '0;
      for (int c = 0; c < 3; c++) ones_cnt[c] <= '0;
    end else if (accept) begin
      win_cnt <= win_cnt + 1'b1;
      for (int c = 0; c < 3; c++) ones_cnt[c] <= final_sample ? '0 : ones_next[c];
    end
  end

  // Level capture, registered valid pulse and sticky saturation flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_valid <= 1'b0;
      sat_err     <= 1'b0;
      for (int c = 0; c < 3; c++) level_q[c] <= '0;
    end else begin
      level_valid <= final_sample;
      if (final_sample) begin
        for (int c = 0; c < 3; c++) level_q[c] <= sat_lvl[c];
        if (any_sat) sat_err <= 1'b1;
      end
    end
  end

`ifdef PWM_LED_DEC_CHANGE_EN
  logic [WIDTH-1:0] prev_q [3];

  // Remember the levels being replaced so the valid cycle can compare old vs new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) prev_q[c] <= '0;
    end else if (final_sample) begin
      for (int c = 0; c < 3; c++) prev_q[c] <= level_q[c];
    end
  end

  assign changed = level_valid &&
                   ((level_q[0] != prev_q[0]) || (level_q[1] != prev_q[1]) ||
                    (level_q[2] != prev_q[2]));
`endif

endmodule

// File: tb/tb_pwm_led_decoder.sv
// Bench for pwm_led_decoder: carry-accumulator stream generators, a window-level
// reference model, directed scenarios and a randomized run.
module tb_pwm_led_decoder;
  localparam int W  = 4;
  localparam int SS = 2;
  localparam int N  = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sample_en = 1'b0;
  logic         clear = 1'b0;
  logic [2:0]   pdm_in = 3'b0;
  logic [W-1:0] level_b, level_g, level_r;
  logic         level_valid, sat_err, fsm_state;
`ifdef PWM_LED_DEC_CHANGE_EN
  logic         changed;
`endif

  pwm_led_decoder #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .clear(clear), .pdm_in(pdm_in),
    .level_b(level_b), .level_g(level_g), .level_r(level_r),
    .level_valid(level_valid), .sat_err(sat_err),
`ifdef PWM_LED_DEC_CHANGE_EN
    .changed(changed),
`endif
    .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // stream generators: code 0..15 gives first-order carry PWM, 16 ties the line high
  logic [3:0] acc  [3];
  logic [4:0] code [3];

  // reference model state
  logic [2:0]      hist [$];
  logic [3*W-1:0]  exp_q [$];
  int              m_flush, m_cnt;
  int              m_ones [3];
  logic [W-1:0]    m_lvl [3];
  logic            m_sat, m_chg;
  int              cyc, last_valid_cyc, gap, valid_seen;
  logic            chg_log [$];

  task automatic model_reset();
    hist.delete(); exp_q.delete();
    m_flush = 0; m_cnt = 0; m_sat = 1'b0; m_chg = 1'b0;
    for (int c = 0; c < 3; c++) begin m_ones[c] = 0; m_lvl[c] = '0; end
    valid_seen = 0; gap = 0; last_valid_cyc = 0;
  endtask

  // One clock cycle: enter at negedge, drive, model the edge, check, leave at next negedge.
  task automatic step(input logic en, input logic clr);
    logic [2:0]     bits, s;
    logic [4:0]     sum;
    logic           m_valid;
    logic [3*W-1:0] e;
    int             lv;
    for (int c = 0; c < 3; c++) begin
      sum = {1'b0, acc[c]} + code[c];
      bits[c] = sum[4];
      if (en) acc[c] = sum[3:0];
    end
    pdm_in = bits; sample_en = en; clear = clr;
    @(posedge clk);
    cyc++;
    hist.push_front(bits);
    if (hist.size() > SS + 1) void'(hist.pop_back());
    s = (hist.size() > SS) ? hist[SS] : 3'b0;
    m_valid = 1'b0;
    if (m_flush < SS) begin
      if (en) m_flush++;
    end else if (clr) begin
      m_cnt = 0;
      for (int c = 0; c < 3; c++) m_ones[c] = 0;
    end else if (en) begin
      for (int c = 0; c < 3; c++) m_ones[c] += int'(s[c]);
      m_cnt++;
      if (m_cnt == N) begin
        m_chg = 1'b0;
        for (int c = 0; c < 3; c++) begin
          lv = (m_ones[c] > N - 1) ? N - 1 : m_ones[c];
          if (m_ones[c] >= N) m_sat = 1'b1;
          if (W'(lv) != m_lvl[c]) m_chg = 1'b1;
          m_lvl[c] = W'(lv);
          m_ones[c] = 0;
        end
        exp_q.push_back({m_lvl[2], m_lvl[1], m_lvl[0]});
        m_cnt = 0;
        m_valid = 1'b1;
      end
    end
    #1;
    check("valid", level_valid, m_valid);
    check("sat_err", sat_err, m_sat);
    check("level_b", level_b, m_lvl[0]);
    check("level_g", level_g, m_lvl[1]);
    check("level_r", level_r, m_lvl[2]);
`ifdef PWM_LED_DEC_CHANGE_EN
    check("changed", changed, m_valid & m_chg);
`endif
    if (level_valid === 1'b1) begin
      valid_seen++;
      gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
`ifdef PWM_LED_DEC_CHANGE_EN
      chg_log.push_back(changed);
`endif
      if (exp_q.size() == 0) check("sb_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sb_levels", {level_r, level_g, level_b}, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must drop without a clock edge.
  task automatic do_reset();
    #3 reset = 1'b0;
    #1;
    check("rst_b", level_b, 0);
    check("rst_g", level_g, 0);
    check("rst_r", level_r, 0);
    check("rst_valid", level_valid, 0);
    check("rst_sat", sat_err, 0);
    model_reset();
    sample_en = 1'b0; clear = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_codes(input logic [4:0] b, input logic [4:0] g, input logic [4:0] r);
    code[0] = b; code[1] = g; code[2] = r;
  endtask

  int v0;

  initial begin
    cyc = 0;
    for (int c = 0; c < 3; c++) begin acc[c] = '0; code[c] = '0; end
    chg_log.delete();
    model_reset();
    #1;
    check("init_b", level_b, 0);
    check("init_valid", level_valid, 0);
    check("init_sat", sat_err, 0);
    @(negedge clk); reset = 1'b1;

    // 1: B=5 G=0 R=15 continuous strobes
    set_codes(5'd5, 5'd0, 5'd15);
    run(SS + 3 * N);
    check("t1_b", level_b, 5);
    check("t1_g", level_g, 0);
    check("t1_r", level_r, 15);
    check("t1_count", valid_seen, 3);
    check("t1_gap", gap, N);
    check("t1_sat", sat_err, 0);

    // 2: B tied high saturates; sat_err survives clear
    do_reset();
    set_codes(5'd16, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    run(SS + N);
    check("t2_b", level_b, 15);
    check("t2_sat", sat_err, 1);
    step(1'b1, 1'b1);
    run(5);
    check("t2_sat_clear", sat_err, 1);

    // 3: one strobe in three, code 9 on G
    do_reset();
    set_codes(5'($urandom_range(0, 15)), 5'd9, 5'($urandom_range(0, 15)));
    for (int i = 0; i < SS + 2 * N; i++) begin
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    end
    check("t3_g", level_g, 9);
    check("t3_count", valid_seen, 2);
    check("t3_gap", gap, 3 * N);

    // 4: clear mid-window and clear on the final sample
    do_reset();
    set_codes(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    run(SS + N + 7);
    v0 = valid_seen;
    step(1'b1, 1'b1);
    run(N - 1);
    check("t4_no_early", valid_seen, v0);
    run(1);
    check("t4_after_clear", valid_seen, v0 + 1);
    run(N - 1);
    step(1'b1, 1'b1);
    run(1);
    check("t4_final_clear", valid_seen, v0 + 1);
    run(N - 1);
    check("t4_resume", valid_seen, v0 + 2);

    // 5: reset mid-window with R=12
    do_reset();
    set_codes(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'd12);
    run(SS + N + 5);
    check("t5_r", level_r, 12);
    do_reset();
    run(SS + N - 1);
    check("t5_no_valid", valid_seen, 0);
    run(1);
    check("t5_first_valid", valid_seen, 1);

`ifdef PWM_LED_DEC_CHANGE_EN
    // 6: B code 3 -> 3 -> 4, change aligned to a window boundary
    do_reset();
    chg_log.delete();
    set_codes(5'd3, 5'd0, 5'd0);
    run(SS + 2 * N - 2);
    code[0] = 5'd4;
    run(N + 2);
    check("t6_count", chg_log.size(), 3);
    if (chg_log.size() == 3) begin
      check("t6_chg0", chg_log[0], 1);
      check("t6_chg1", chg_log[1], 0);
      check("t6_chg2", chg_log[2], 1);
    end
    check("t6_b", level_b, 4);
`endif

    // random: gappy strobes, rare clears, code changes, occasional reset
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0)
        for (int c = 0; c < 3; c++) code[c] = 5'($urandom_range(0, 16));
      if ($urandom_range(0, 499) == 0) do_reset();
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
    end
    check("q_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
